branch_resolve_queue: RTL and testbench

In-order queue of outstanding branch predictions, sitting directly downstream of the 2-bit saturating-counter predictor. It records each issued prediction, pairs it with the branch outcome resolved in execute, and drives the predictor's training inputs (`result`/`taken`). It also raises a one-cycle mispredict redirect that squashes all younger queued branches.

---
 rtl/brq_pkg.sv | 28 ++
 rtl/brq_storage.sv | 37 +++
 rtl/branch_resolve_queue.sv | 149 ++++++++++++++
 tb/tb_branch_resolve_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : brq_pkg
// Description : Shared types and constants for the branch resolve queue.
// Revision    : 1.0 - initial release
// ============================================================================
package brq_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_PC_W  = 32;
  localparam int DEFAULT_CNT_W = 16;

  // Entry PC field is sized for the widest supported PC; narrower
  // configurations zero-pad on write and truncate on read.
  localparam int PC_MAX_W = 64;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic                taken;
  } brq_entry_t;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int brq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/brq_storage.sv
`default_nettype none
// ============================================================================
// Module      : brq_storage
// Description : DEPTH x entry register array, one write port and a
//               combinational read of the addressed (head) entry.
// Revision    : 1.0 - initial release
// ============================================================================
module brq_storage
  import brq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  brq_entry_t       wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output brq_entry_t       rdata_o
);

  brq_entry_t mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the pushed entry into its slot; contents need no reset since
    // occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
      if (we_i && (waddr_i == AW'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue
// Description : In-order queue of outstanding branch predictions. Pairs each
//               prediction with its resolved outcome, trains the predictor,
//               and raises a one-cycle mispredict redirect that squashes all
//               younger queued branches.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PC_W  = DEFAULT_PC_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  input  logic [PC_W-1:0]          pred_pc,
  output logic                     pred_ready,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [PC_W-1:0]          resolve_pc,
  input  logic                     flush,
  output logic                     upd_result,
  output logic                     upd_taken,
  output logic                     mispredict,
  output logic [PC_W-1:0]          mispredict_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     order_err,
  output logic                     underflow_err,
  output logic [CNT_W-1:0]         mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = brq_ptr_w(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    rptr_next;
  logic             empty, full;
  logic             do_pop, do_push, mispredict_now, squash;
  brq_entry_t       head;
  brq_entry_t       push_entry;
  logic [PC_W-1:0]  head_pc;

  logic             upd_result_q, upd_taken_q, mispredict_q;
  logic [PC_W-1:0]  mispredict_pc_q;
  logic             order_err_q, underflow_err_q;
  logic [CNT_W-1:0] mispredict_cnt_q;

  // ---------------------------------------------------------------- storage
  assign push_entry.pc    = PC_MAX_W'(pred_pc);
  assign push_entry.taken = pred_taken;

  brq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (push_entry),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (head)
  );

  assign head_pc = head.pc[PC_W-1:0];

  if (PC_W < PC_MAX_W) begin : g_pc_pad
    logic unused_head_pc_hi;
    assign unused_head_pc_hi = |head.pc[PC_MAX_W-1:PC_W];
  end

  // ------------------------------------------------------------ status/flow
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Ready depends only on current occupancy; a same-cycle pop does not help.
  assign pred_ready     = !full;
  assign do_pop         = resolve_valid && !empty;
  assign mispredict_now = do_pop && (head.taken != resolve_taken);
  assign squash         = flush || mispredict_now;
  assign do_push        = pred_valid && pred_ready && !flush && !mispredict_now;
  assign count          = wptr_q - rptr_q;

  // Next pointer values: a squash collapses the write pointer onto the
  // post-pop read pointer so everything younger is discarded.
  always_comb begin
    rptr_next = rptr_q + (do_pop ? PW'(1) : PW'(0));
    rptr_d    = rptr_next;
    wptr_d    = wptr_q + (do_push ? PW'(1) : PW'(0));
    if (squash) begin
      wptr_d = rptr_next;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Registered training/redirect outputs, sticky errors and mispredict stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_result_q     <= 1'b0;
      upd_taken_q      <= 1'b0;
      mispredict_q     <= 1'b0;
      mispredict_pc_q  <= '0;
      order_err_q      <= 1'b0;
      underflow_err_q  <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      upd_result_q <= do_pop;
      mispredict_q <= mispredict_now;
      if (do_pop) begin
        upd_taken_q     <= resolve_taken;
        mispredict_pc_q <= head_pc;
      end
      if (do_pop && (resolve_pc != head_pc)) begin
        order_err_q <= 1'b1;
      end
      if (resolve_valid && empty) begin
        underflow_err_q <= 1'b1;
      end
      if (mispredict_now && (mispredict_cnt_q != {CNT_W{1'b1}})) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign upd_result     = upd_result_q;
  assign upd_taken      = upd_taken_q;
  assign mispredict     = mispredict_q;
  assign mispredict_pc  = mispredict_pc_q;
  assign order_err      = order_err_q;
  assign underflow_err  = underflow_err_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_queue
// Description : Directed self-checking bench for branch_resolve_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             pred_valid, pred_taken;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_ready;
  logic             resolve_valid, resolve_taken;
  logic [PC_W-1:0]  resolve_pc;
  logic             flush;
  logic             upd_result, upd_taken, mispredict;
  logic [PC_W-1:0]  mispredict_pc;
  logic [2:0]       count;
  logic             order_err, underflow_err;
  logic [CNT_W-1:0] mispredict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_pc        (pred_pc),
    .pred_ready     (pred_ready),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_pc     (resolve_pc),
    .flush          (flush),
    .upd_result     (upd_result),
    .upd_taken      (upd_taken),
    .mispredict     (mispredict),
    .mispredict_pc  (mispredict_pc),
    .count          (count),
    .order_err      (order_err),
    .underflow_err  (underflow_err),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"},          64'(count),          64'd0);
    chk({tag, ".pred_ready"},     64'(pred_ready),     64'd1);
    chk({tag, ".upd_result"},     64'(upd_result),     64'd0);
    chk({tag, ".upd_taken"},      64'(upd_taken),      64'd0);
    chk({tag, ".mispredict"},     64'(mispredict),     64'd0);
    chk({tag, ".mispredict_pc"},  64'(mispredict_pc),  64'd0);
    chk({tag, ".order_err"},      64'(order_err),      64'd0);
    chk({tag, ".underflow_err"},  64'(underflow_err),  64'd0);
    chk({tag, ".mispredict_cnt"}, 64'(mispredict_cnt), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    pred_valid    = 1'b0;
    pred_taken    = 1'b0;
    pred_pc       = '0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    resolve_pc    = '0;
    flush         = 1'b0;
    #1;
    chk_reset_vals("rst");
    step();
    step();
    #3 rst_n = 1'b1;
    step();

    // ---- in-order pushes and correct resolves
    pred_valid = 1; pred_pc = 32'h100; pred_taken = 1; step();
    chk("t1.cnt1", 64'(count), 64'd1);
    pred_pc = 32'h104; pred_taken = 0; step();
    pred_pc = 32'h108; pred_taken = 1; step();
    chk("t1.cnt3", 64'(count), 64'd3);
    pred_valid = 0;
    resolve_valid = 1; resolve_pc = 32'h100; resolve_taken = 1; step();
    chk("t1.upd0",    64'(upd_result), 64'd1);
    chk("t1.tkn0",    64'(upd_taken),  64'd1);
    chk("t1.mis0",    64'(mispredict), 64'd0);
    chk("t1.cnt2",    64'(count),      64'd2);
    resolve_pc = 32'h104; resolve_taken = 0; step();
    chk("t1.upd1",    64'(upd_result), 64'd1);
    chk("t1.tkn1",    64'(upd_taken),  64'd0);
    chk("t1.mis1",    64'(mispredict), 64'd0);
    resolve_pc = 32'h108; resolve_taken = 1; step();
    chk("t1.upd2",    64'(upd_result), 64'd1);
    chk("t1.tkn2",    64'(upd_taken),  64'd1);
    chk("t1.mis2",    64'(mispredict), 64'd0);
    chk("t1.cnt0",    64'(count),      64'd0);
    idle(); step();
    chk("t1.updoff",  64'(upd_result), 64'd0);

    // ---- fill to full, push while full, push+pop around full
    pred_valid = 1; pred_taken = 1;
    pred_pc = 32'h10; step();
    pred_pc = 32'h14; step();
    pred_pc = 32'h18; step();
    pred_pc = 32'h1C; step();
    chk("t2.full_cnt",   64'(count),      64'd4);
    chk("t2.full_ready", 64'(pred_ready), 64'd0);
    pred_pc = 32'h20; step();
    chk("t2.drop_cnt",   64'(count),      64'd4);
    // Pop while full: ready was low, so the concurrent push is dropped.
    resolve_valid = 1; resolve_pc = 32'h10; resolve_taken = 1; step();
    chk("t2.popfull_cnt", 64'(count),        64'd3);
    chk("t2.popfull_pc",  64'(mispredict_pc), 64'h10);
    // Push + pop with room: occupancy unchanged, new entry goes at tail.
    pred_pc = 32'h24; resolve_pc = 32'h14; step();
    chk("t2.pp_cnt",     64'(count),      64'd3);
    pred_valid = 0;
    resolve_pc = 32'h18; step();
    chk("t2.d18",        64'(mispredict_pc), 64'h18);
    resolve_pc = 32'h1C; step();
    chk("t2.d1C",        64'(mispredict_pc), 64'h1C);
    resolve_pc = 32'h24; step();
    chk("t2.d24",        64'(mispredict_pc), 64'h24);
    chk("t2.cnt0",       64'(count),      64'd0);
    chk("t2.noorder",    64'(order_err),  64'd0);
    idle(); step();

    // ---- mispredict squashes younger entries and drops concurrent push
    pred_valid = 1; pred_pc = 32'h200; pred_taken = 0; step();
    pred_pc = 32'h204; pred_taken = 1; step();
    pred_pc = 32'h208; pred_taken = 1;
    resolve_valid = 1; resolve_pc = 32'h200; resolve_taken = 1; step();
    chk("t3.mis",     64'(mispredict),     64'd1);
    chk("t3.mispc",   64'(mispredict_pc),  64'h200);
    chk("t3.cnt",     64'(count),          64'd0);
    chk("t3.stat",    64'(mispredict_cnt), 64'd1);
    chk("t3.upd",     64'(upd_result),     64'd1);
    idle(); step();
    chk("t3.mispulse", 64'(mispredict),    64'd0);
    chk("t3.cnt_after", 64'(count),        64'd0);

    // ---- underflow and order error
    resolve_valid = 1; resolve_pc = 32'h300; resolve_taken = 1; step();
    chk("t4.uflow",   64'(underflow_err), 64'd1);
    chk("t4.noupd",   64'(upd_result),    64'd0);
    chk("t4.cnt",     64'(count),         64'd0);
    idle();
    pred_valid = 1; pred_pc = 32'h304; pred_taken = 1; step();
    pred_valid = 0;
    resolve_valid = 1; resolve_pc = 32'h300; resolve_taken = 1; step();
    chk("t4.order",   64'(order_err),     64'd1);
    chk("t4.upd",     64'(upd_result),    64'd1);
    chk("t4.mispc",   64'(mispredict_pc), 64'h304);
    chk("t4.nomis",   64'(mispredict),    64'd0);
    chk("t4.cnt0",    64'(count),         64'd0);
    idle(); step();

    // ---- flush with concurrent correct resolve and dropped push
    pred_valid = 1; pred_taken = 1; pred_pc = 32'h400; step();
    pred_taken = 0; pred_pc = 32'h404; step();
    chk("t5.cnt2",    64'(count), 64'd2);
    pred_pc = 32'h408; flush = 1;
    resolve_valid = 1; resolve_pc = 32'h400; resolve_taken = 1; step();
    chk("t5.upd",     64'(upd_result), 64'd1);
    chk("t5.nomis",   64'(mispredict), 64'd0);
    chk("t5.cnt0",    64'(count),      64'd0);
    idle(); step();
    chk("t5.cntstay", 64'(count),      64'd0);
    chk("t5.stat",    64'(mispredict_cnt), 64'd1);

    // ---- build mispredict count to 5, then async reset mid-queue
    for (int i = 0; i < 4; i++) begin
      pred_valid = 1; pred_pc = 32'h500; pred_taken = 1; step();
      pred_valid = 0;
      resolve_valid = 1; resolve_pc = 32'h500; resolve_taken = 0; step();
      resolve_valid = 0;
    end
    chk("t6.stat5",   64'(mispredict_cnt), 64'd5);
    pred_valid = 1; pred_taken = 1;
    pred_pc = 32'h600; step();
    pred_pc = 32'h604; step();
    pred_pc = 32'h608; step();
    pred_valid = 0;
    resolve_valid = 1; resolve_pc = 32'h600; resolve_taken = 1; step();
    chk("t6.pending", 64'(upd_result), 64'd1);
    chk("t6.cnt2",    64'(count),      64'd2);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("t6.async");
    step();
    #3 rst_n = 1'b1;
    step();
    chk("t6.post_cnt",  64'(count),      64'd0);
    chk("t6.post_upd",  64'(upd_result), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
